// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the 6502 fetch sequencer: PC commands,
// address type, sequencer states and the opcodes that redirect the PC.
package pc_sequencer_pkg;

  typedef logic [15:0] addr_t;

  typedef enum logic [1:0] {
    PS_HOLD = 2'd0,
    PS_INC  = 2'd1,
    PS_ABS  = 2'd2
  } ps_t;

  typedef enum logic [2:0] {
    RST_LO = 3'd0,
    RST_HI = 3'd1,
    FETCH  = 3'd2,
    OPER1  = 3'd3,
    OPER2  = 3'd4,
    IND_LO = 3'd5,
    IND_HI = 3'd6
  } seq_state_t;

  localparam logic [7:0] OP_JMP_ABS        = 8'h4C;
  localparam logic [7:0] OP_JMP_IND        = 8'h6C;
  localparam addr_t      RESET_VEC_DEFAULT = 16'hFFFC;

endpackage

// File: rtl/pc_sequencer_opcode_len.sv
// Instruction length (1..3 bytes) for the documented 6502 opcode set;
// undocumented opcodes are treated as single-byte.
module opcode_len (
  input  logic [7:0] opcode,
  output logic [1:0] len
);

  always_comb begin
    len = 2'd1;
    case (opcode)
      8'h0D, 8'h19, 8'h1D, 8'h2D, 8'h39, 8'h3D, 8'h4D, 8'h59,
      8'h5D, 8'h6D, 8'h79, 8'h7D, 8'h8D, 8'h99, 8'h9D, 8'hAD,
      8'hB9, 8'hBD, 8'hCD, 8'hD9, 8'hDD, 8'hED, 8'hF9, 8'hFD,
      8'h0E, 8'h1E, 8'h2E, 8'h3E, 8'h4E, 8'h5E, 8'h6E, 8'h7E,
      8'h8E, 8'hAE, 8'hBE, 8'hCE, 8'hDE, 8'hEE, 8'hFE,
      8'h20, 8'h2C, 8'h4C, 8'h6C, 8'h8C, 8'hAC, 8'hBC, 8'hCC,
      8'hEC:
        len = 2'd3;
      8'h01, 8'h05, 8'h09, 8'h11, 8'h15, 8'h21, 8'h25, 8'h29,
      8'h31, 8'h35, 8'h41, 8'h45, 8'h49, 8'h51, 8'h55, 8'h61,
      8'h65, 8'h69, 8'h71, 8'h75, 8'h81, 8'h85, 8'h91, 8'h95,
      8'hA1, 8'hA5, 8'hA9, 8'hB1, 8'hB5, 8'hC1, 8'hC5, 8'hC9,
      8'hD1, 8'hD5, 8'hE1, 8'hE5, 8'hE9, 8'hF1, 8'hF5,
      8'h06, 8'h16, 8'h26, 8'h36, 8'h46, 8'h56, 8'h66, 8'h76,
      8'h86, 8'h96, 8'hA2, 8'hA6, 8'hB6, 8'hC6, 8'hD6, 8'hE6,
      8'hF6,
      8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0,
      8'h24, 8'h84, 8'h94, 8'hA0, 8'hA4, 8'hB4, 8'hC0, 8'hC4,
      8'hE0, 8'hE4:
        len = 2'd2;
      default: len = 2'd1;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side control for the 6502 core: loads the reset vector, walks
// opcode/operand bytes at pc and redirects the PC for JMP abs / JMP ind.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter addr_t RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  addr_t       pc,
  input  logic [7:0]  mem_data,
  input  logic        stall,
  output ps_t         ps,
  output addr_t       pc_abs,
  output addr_t       addr,
  output logic [7:0]  opcode,
  output logic        opcode_valid,
  output logic [15:0] operand,
  output logic        operand_valid
);

  seq_state_t  state, state_next;
  logic [7:0]  lo, hi, tgt_lo;
  logic [7:0]  lo_next, hi_next, tgt_lo_next, opcode_next;
  logic [15:0] operand_next;
  logic        opcode_valid_next, operand_valid_next;
  logic [7:0]  len_opcode;
  logic [1:0]  len;
  ps_t         ps_raw;

  // In FETCH the opcode is still on the bus; afterwards it sits in the register.
  assign len_opcode = (state == FETCH) ? mem_data : opcode;

  opcode_len u_opcode_len (
    .opcode (len_opcode),
    .len    (len)
  );

  // Stall and reset both freeze the PC.
  assign ps = (reset || stall) ? PS_HOLD : ps_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RST_LO;
      lo            <= '0;
      hi            <= '0;
      tgt_lo        <= '0;
      opcode        <= '0;
      operand       <= '0;
      opcode_valid  <= 1'b0;
      operand_valid <= 1'b0;
    end else if (stall) begin
      opcode_valid  <= 1'b0;
      operand_valid <= 1'b0;
    end else begin
      state         <= state_next;
      lo            <= lo_next;
      hi            <= hi_next;
      tgt_lo        <= tgt_lo_next;
      opcode        <= opcode_next;
      operand       <= operand_next;
      opcode_valid  <= opcode_valid_next;
      operand_valid <= operand_valid_next;
    end
  end

  always_comb begin
    state_next         = state;
    ps_raw             = PS_HOLD;
    pc_abs             = '0;
    addr               = pc;
    lo_next            = lo;
    hi_next            = hi;
    tgt_lo_next        = tgt_lo;
    opcode_next        = opcode;
    operand_next       = operand;
    opcode_valid_next  = 1'b0;
    operand_valid_next = 1'b0;
    case (state)
      RST_LO: begin
        addr       = RESET_VEC;
        lo_next    = mem_data;
        state_next = RST_HI;
      end
      RST_HI: begin
        addr       = addr_t'(RESET_VEC + 16'd1);
        ps_raw     = PS_ABS;
        pc_abs     = {mem_data, lo};
        state_next = FETCH;
      end
      FETCH: begin
        opcode_next       = mem_data;
        opcode_valid_next = 1'b1;
        ps_raw            = PS_INC;
        state_next        = (len > 2'd1) ? OPER1 : FETCH;
      end
      OPER1: begin
        lo_next = mem_data;
        ps_raw  = PS_INC;
        if (len == 2'd2) begin
          operand_next       = {8'h00, mem_data};
          operand_valid_next = 1'b1;
          state_next         = FETCH;
        end else begin
          state_next = OPER2;
        end
      end
      OPER2: begin
        hi_next            = mem_data;
        operand_next       = {mem_data, lo};
        operand_valid_next = 1'b1;
        if (opcode == OP_JMP_ABS) begin
          ps_raw     = PS_ABS;
          pc_abs     = {mem_data, lo};
          state_next = FETCH;
        end else if (opcode == OP_JMP_IND) begin
          ps_raw     = PS_HOLD;
          state_next = IND_LO;
        end else begin
          ps_raw     = PS_INC;
          state_next = FETCH;
        end
      end
      IND_LO: begin
        addr        = {hi, lo};
        tgt_lo_next = mem_data;
        state_next  = IND_HI;
      end
      IND_HI: begin
        // NMOS quirk: the pointer increment never carries into the high byte.
        addr       = {hi, 8'(lo + 8'd1)};
        ps_raw     = PS_ABS;
        pc_abs     = {mem_data, tgt_lo};
        state_next = FETCH;
      end
      default: state_next = RST_LO;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: an instruction-level model walks the
// program in memory and predicts per-cycle address, PC command and pulses.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int MAXK = 512;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  addr_t       pc = '0;
  logic [7:0]  mem_data;
  ps_t         ps;
  addr_t       pc_abs, addr;
  logic [7:0]  opcode;
  logic        opcode_valid;
  logic [15:0] operand;
  logic        operand_valid;

  logic [7:0]  mem [0:65535];

  int checks = 0;
  int failures = 0;

  bit          is_fetch [0:MAXK-1];
  logic [7:0]  fetch_op [0:MAXK-1];
  bit          opr_end  [0:MAXK-1];
  logic [15:0] opr_val  [0:MAXK-1];
  ps_t         exp_ps   [0:MAXK-1];
  addr_t       exp_abs  [0:MAXK-1];
  addr_t       exp_addr [0:MAXK-1];

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .mem_data      (mem_data),
    .stall         (stall),
    .ps            (ps),
    .pc_abs        (pc_abs),
    .addr          (addr),
    .opcode        (opcode),
    .opcode_valid  (opcode_valid),
    .operand       (operand),
    .operand_valid (operand_valid)
  );

  assign mem_data = mem[addr];

  always #5 clk = ~clk;

  // Program counter stand-in: registered, follows ps one edge later.
  always @(posedge clk) begin
    if (ps == PS_INC) pc <= pc + 16'd1;
    else if (ps == PS_ABS) pc <= pc_abs;
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [7:0] rd(input addr_t a);
    return mem[a];
  endfunction

  // Instruction length from 6502 addressing-mode rules (aaa bbb cc fields).
  function automatic int ref_len(input logic [7:0] op);
    logic [2:0] bbb;
    bbb = op[4:2];
    case (op[1:0])
      2'b01: begin
        if (op == 8'h89) return 1;
        return (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 3 : 2;
      end
      2'b10: begin
        case (bbb)
          3'b000: return (op == 8'hA2) ? 2 : 1;
          3'b001: return 2;
          3'b011: return 3;
          3'b101: return 2;
          3'b111: return (op == 8'h9E) ? 1 : 3;
          default: return 1;
        endcase
      end
      2'b00: begin
        case (bbb)
          3'b000: begin
            if (op == 8'h20) return 3;
            return (op == 8'hA0 || op == 8'hC0 || op == 8'hE0) ? 2 : 1;
          end
          3'b001: return (op == 8'h24 || op == 8'h84 || op == 8'hA4 || op == 8'hC4 || op == 8'hE4) ? 2 : 1;
          3'b011: return (op == 8'h0C) ? 1 : 3;
          3'b100: return 2;
          3'b101: return (op == 8'h94 || op == 8'hB4) ? 2 : 1;
          3'b111: return (op == 8'hBC) ? 3 : 1;
          default: return 1;
        endcase
      end
      default: return 1;
    endcase
  endfunction

  // Walk the program from the reset vector and lay out the expected cycle stream.
  task automatic buildSchedule();
    addr_t p, ptr, ptr2, tgt;
    logic [7:0] op;
    int len, k;
    for (int i = 0; i < MAXK; i++) begin
      is_fetch[i] = 1'b0; opr_end[i] = 1'b0; fetch_op[i] = '0; opr_val[i] = '0;
      exp_ps[i] = PS_HOLD; exp_abs[i] = '0; exp_addr[i] = '0;
    end
    exp_addr[0] = RESET_VEC_DEFAULT;
    exp_addr[1] = addr_t'(RESET_VEC_DEFAULT + 16'd1);
    exp_ps[1]   = PS_ABS;
    p = {rd(addr_t'(RESET_VEC_DEFAULT + 16'd1)), rd(RESET_VEC_DEFAULT)};
    exp_abs[1] = p;
    k = 2;
    while (k < MAXK - 5) begin
      op = rd(p);
      len = ref_len(op);
      is_fetch[k] = 1'b1;
      fetch_op[k] = op;
      for (int b = 0; b < len; b++) begin
        exp_addr[k+b] = addr_t'(p + addr_t'(b));
        exp_ps[k+b]   = PS_INC;
      end
      if (len == 2) begin
        opr_end[k+1] = 1'b1;
        opr_val[k+1] = {8'h00, rd(addr_t'(p + 16'd1))};
      end else if (len == 3) begin
        opr_end[k+2] = 1'b1;
        opr_val[k+2] = {rd(addr_t'(p + 16'd2)), rd(addr_t'(p + 16'd1))};
      end
      if (op == OP_JMP_ABS) begin
        tgt = {rd(addr_t'(p + 16'd2)), rd(addr_t'(p + 16'd1))};
        exp_ps[k+2] = PS_ABS;
        exp_abs[k+2] = tgt;
        p = tgt;
        k += 3;
      end else if (op == OP_JMP_IND) begin
        ptr  = {rd(addr_t'(p + 16'd2)), rd(addr_t'(p + 16'd1))};
        ptr2 = {ptr[15:8], 8'(ptr[7:0] + 8'd1)};
        tgt  = {rd(ptr2), rd(ptr)};
        exp_ps[k+2] = PS_HOLD;
        exp_addr[k+3] = ptr;
        exp_ps[k+3] = PS_HOLD;
        exp_addr[k+4] = ptr2;
        exp_ps[k+4] = PS_ABS;
        exp_abs[k+4] = tgt;
        p = tgt;
        k += 5;
      end else begin
        p = addr_t'(p + addr_t'(len));
        k += len;
      end
    end
  endtask

  // Reset, then run n cycles with random stalls, an optional forced 3-cycle
  // stall at active cycle stall_k, and an optional reset abort at abort_k.
  task automatic applyStimulus(input int n_cycles, input int stall_pct, input int stall_k, input int abort_k);
    int k, hold_cnt;
    bit used, exp_opv, exp_oprv;
    logic [7:0] exp_op;
    logic [15:0] exp_opr;
    buildSchedule();
    reset = 1'b1;
    stall = 1'($urandom_range(1));
    #1 checkOutput("rst_ps", 16'(ps), 16'(PS_HOLD));
    @(negedge clk);
    stall = 1'($urandom_range(1));
    #1 checkOutput("rst_ps", 16'(ps), 16'(PS_HOLD));
    @(negedge clk);
    reset = 1'b0;
    k = 0; hold_cnt = 0; used = 1'b0;
    exp_opv = 1'b0; exp_oprv = 1'b0; exp_op = '0; exp_opr = '0;
    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      if (k == abort_k) begin
        reset = 1'b1;
        stall = 1'($urandom_range(1));
        #1 checkOutput("abort_ps", 16'(ps), 16'(PS_HOLD));
        @(negedge clk);
        return;
      end
      if (hold_cnt > 0) begin
        stall = 1'b1;
        hold_cnt--;
      end else if (!used && k == stall_k) begin
        stall = 1'b1;
        hold_cnt = 2;
        used = 1'b1;
      end else begin
        stall = ($urandom_range(99) < stall_pct);
      end
      #1;
      if (cyc == 0) begin
        checkOutput("rst_opcode", 16'(opcode), 16'h0000);
        checkOutput("rst_operand", operand, 16'h0000);
      end
      checkOutput("opcode_valid", 16'(opcode_valid), 16'(exp_opv));
      if (exp_opv) checkOutput("opcode", 16'(opcode), 16'(exp_op));
      checkOutput("operand_valid", 16'(operand_valid), 16'(exp_oprv));
      if (exp_oprv) checkOutput("operand", operand, exp_opr);
      checkOutput("addr", addr, exp_addr[k]);
      if (stall) begin
        checkOutput("stall_ps", 16'(ps), 16'(PS_HOLD));
        exp_opv = 1'b0;
        exp_oprv = 1'b0;
      end else begin
        checkOutput("ps", 16'(ps), 16'(exp_ps[k]));
        if (exp_ps[k] == PS_ABS) checkOutput("pc_abs", pc_abs, exp_abs[k]);
        exp_opv = is_fetch[k];
        exp_op = fetch_op[k];
        exp_oprv = opr_end[k];
        exp_opr = opr_val[k];
        k++;
      end
      @(negedge clk);
    end
    stall = 1'b0;
  endtask

  task automatic clearMem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'hC0;
  endtask

  initial begin
    @(negedge clk);

    $display("[TB] reset vector and NOP run");
    clearMem();
    mem[16'hC004] = 8'h4C; mem[16'hC005] = 8'h00; mem[16'hC006] = 8'hC0;
    applyStimulus(20, 0, -1, -1);

    $display("[TB] LDA immediate, with 3-cycle stall in OPER1");
    clearMem();
    mem[16'hC000] = 8'hA9; mem[16'hC001] = 8'h42;
    applyStimulus(12, 0, -1, -1);
    applyStimulus(12, 0, 3, -1);

    $display("[TB] JMP absolute");
    clearMem();
    mem[16'hC000] = 8'h4C; mem[16'hC001] = 8'h34; mem[16'hC002] = 8'h12;
    applyStimulus(12, 0, -1, -1);

    $display("[TB] JMP indirect page wrap, then reset in IND_LO");
    clearMem();
    mem[16'hC000] = 8'h6C; mem[16'hC001] = 8'hFF; mem[16'hC002] = 8'h10;
    mem[16'h10FF] = 8'h78; mem[16'h1000] = 8'h56; mem[16'h1100] = 8'h99;
    applyStimulus(14, 0, -1, -1);
    applyStimulus(14, 0, -1, 5);
    applyStimulus(14, 0, -1, -1);

    $display("[TB] PC wrap at FFFF");
    clearMem();
    mem[16'hFFFC] = 8'hFE; mem[16'hFFFD] = 8'hFF;
    mem[16'hFFFE] = 8'hEA; mem[16'hFFFF] = 8'hEA;
    mem[16'h0000] = 8'hA9; mem[16'h0001] = 8'h11;
    applyStimulus(12, 0, -1, -1);

    $display("[TB] randomized programs");
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 65536; i++) begin
        case ($urandom_range(15))
          0: mem[i] = OP_JMP_IND;
          1: mem[i] = OP_JMP_ABS;
          default: mem[i] = 8'($urandom_range(255));
        endcase
      end
      applyStimulus(300, 20, $urandom_range(2, 40), (r % 2 == 1) ? int'($urandom_range(5, 200)) : -1);
      applyStimulus(200, 10, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
